// File: rtl/sblk_act_loader.sv
// Activation loader: scatters a valid/ready word stream tile-major into the stile act buffers,
// ping-ponging two banks. Optional perf counters are built when ACT_LOADER_PERF_EN is defined.
module sblk_act_loader #(
    parameter int N_TILE      = 4,
    parameter int WID_ACT     = 16,
    parameter int WID_ACTADDR = 6
) (
    input  logic                     clk_h,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WID_ACTADDR-2:0]   cfg_len,
    input  logic                     s_valid,
    input  logic [WID_ACT-1:0]       s_data,
    output logic                     s_ready,
    output logic [WID_ACT-1:0]       act_wr_data,
    output logic [N_TILE-1:0]        act_wr_en,
    output logic [WID_ACTADDR-2:0]   act_wr_addr_hbit,
    output logic                     act_wr_bank,
    output logic                     bank_valid,
    output logic                     bank_rd_sel,
    input  logic                     bank_release,
    output logic                     busy,
    output logic                     err_release
`ifdef ACT_LOADER_PERF_EN
    ,
    output logic [31:0]              perf_stall_cyc,
    output logic [15:0]              perf_bank_cnt
`endif
);

    localparam int AW = WID_ACTADDR - 1;
    localparam int TW = (N_TILE > 1) ? $clog2(N_TILE) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(N_TILE - 1);

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  len;
    logic [AW-1:0]  w;
    logic [TW-1:0]  t;
    logic           wr_bank;
    logic           rd_bank;
    logic [1:0]     full_cnt, full_nxt;
    logic           xfer, complete, rel_ok, start_ok;

    // Handshake: a word moves when s_valid && s_ready; s_ready depends on registered state only.
    assign s_ready     = (state == FILL) && (full_cnt < 2'd2);
    assign bank_valid  = (full_cnt != 2'd0);
    assign bank_rd_sel = rd_bank;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        xfer      = s_valid && s_ready;
        complete  = xfer && (w == len) && (t == T_LAST);
        rel_ok    = bank_release && (full_cnt != 2'd0);
        start_ok  = (state == IDLE) && start;
        full_nxt  = full_cnt + {1'b0, complete} - {1'b0, rel_ok};
        case (state)
            IDLE:        if (start) state_nxt = FILL;
            FILL, STALL: state_nxt = (full_nxt == 2'd2) ? STALL : FILL;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            len              <= '0;
            w                <= '0;
            t                <= '0;
            wr_bank          <= 1'b0;
            rd_bank          <= 1'b0;
            full_cnt         <= 2'd0;
            err_release      <= 1'b0;
            act_wr_data      <= '0;
            act_wr_en        <= '0;
            act_wr_addr_hbit <= '0;
            act_wr_bank      <= 1'b0;
        end else begin
            state     <= state_nxt;
            act_wr_en <= '0;
            if (xfer) begin
                act_wr_data      <= s_data;
                act_wr_en        <= {{(N_TILE-1){1'b0}}, 1'b1} << t;
                act_wr_addr_hbit <= w;
                act_wr_bank      <= wr_bank;
            end
            if (start_ok) begin
                len         <= cfg_len;
                w           <= '0;
                t           <= '0;
                wr_bank     <= 1'b0;
                rd_bank     <= 1'b0;
                full_cnt    <= 2'd0;
                err_release <= 1'b0;
            end else begin
                full_cnt <= full_nxt;
                if (rel_ok)
                    rd_bank <= ~rd_bank;
                if (bank_release && (full_cnt == 2'd0))
                    err_release <= 1'b1;
                // Word index runs fastest, then tile; the last word of the last tile closes the bank.
                if (xfer) begin
                    if (w == len) begin
                        w <= '0;
                        if (t == T_LAST) begin
                            t       <= '0;
                            wr_bank <= ~wr_bank;
                        end else begin
                            t <= t + 1'b1;
                        end
                    end else begin
                        w <= w + 1'b1;
                    end
                end
            end
        end
    end

`ifdef ACT_LOADER_PERF_EN
    always_ff @(posedge clk_h or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_bank_cnt  <= '0;
        end else if (start_ok) begin
            perf_stall_cyc <= '0;
            perf_bank_cnt  <= '0;
        end else begin
            if (s_valid && !s_ready && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (complete && (perf_bank_cnt != '1))
                perf_bank_cnt <= perf_bank_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sblk_act_loader.sv
// Directed bench for sblk_act_loader: ordering, stall/release, pointer corner cases,
// error flag, a long randomly-gapped stream against an expected queue, and perf counters.
module tb_sblk_act_loader;

    logic        clk_h = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  cfg_len = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic [15:0] act_wr_data;
    logic [3:0]  act_wr_en;
    logic [4:0]  act_wr_addr_hbit;
    logic        act_wr_bank;
    logic        bank_valid;
    logic        bank_rd_sel;
    logic        bank_release = 1'b0;
    logic        busy;
    logic        err_release;
`ifdef ACT_LOADER_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [15:0] perf_bank_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [25:0] exp_q[$];
    logic [25:0] got_rec;

    assign got_rec = {act_wr_bank, act_wr_en, act_wr_addr_hbit, act_wr_data};

    sblk_act_loader #(.N_TILE(4), .WID_ACT(16), .WID_ACTADDR(6)) dut (
        .clk_h(clk_h), .rst(rst), .start(start), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .act_wr_data(act_wr_data), .act_wr_en(act_wr_en),
        .act_wr_addr_hbit(act_wr_addr_hbit), .act_wr_bank(act_wr_bank),
        .bank_valid(bank_valid), .bank_rd_sel(bank_rd_sel),
        .bank_release(bank_release), .busy(busy), .err_release(err_release)
`ifdef ACT_LOADER_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_bank_cnt(perf_bank_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk_h = ~clk_h;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model helper and drivers ----------------
    function automatic logic [25:0] mk_rec(int bank, int tile, int addr, int data);
        logic [3:0] en;
        en = 4'b0001 << tile;
        return {bank[0], en, addr[4:0], data[15:0]};
    endfunction

    task automatic do_reset();
        @(negedge clk_h);
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; bank_release = 1'b0;
        @(negedge clk_h);
        @(negedge clk_h);
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        start = 1'b1; cfg_len = len;
        @(negedge clk_h);
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        s_valid = 1'b1;
        n_checks++;
        if ({got_rec, bank_valid, bank_rd_sel, busy, err_release, s_ready} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {got_rec, bank_valid, bank_rd_sel, busy, err_release, s_ready});
        end
        @(negedge clk_h);
        n_checks++;
        if ({act_wr_en, busy, s_ready} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idle_no_write: got %b want 0", {act_wr_en, busy, s_ready});
        end
        s_valid = 1'b0;
    endtask

    task automatic test_fill_order();
        do_reset();
        do_start(5'd3);
        for (int i = 0; i <= 17; i++) begin
            if (i > 0) begin
                n_checks++;
                if (got_rec !== mk_rec((i-1)/16, ((i-1)/4)%4, (i-1)%4, i-1)) begin
                    n_fail++;
                    $display("FAIL fill_write word %0d: got %h want %h", i-1, got_rec, mk_rec((i-1)/16, ((i-1)/4)%4, (i-1)%4, i-1));
                end
            end
            n_checks++;
            if (bank_valid !== (i >= 16)) begin
                n_fail++;
                $display("FAIL fill_bank_valid at %0d: got %b want %b", i, bank_valid, (i >= 16));
            end
            if (i == 16) begin
                n_checks++;
                if (bank_rd_sel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_rd_sel: got %b want 0", bank_rd_sel);
                end
            end
            if (i < 17) begin
                s_valid = 1'b1; s_data = 16'(i);
                n_checks++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fill_ready at %0d: got %b want 1", i, s_ready);
                end
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk_h);
        end
    endtask

    task automatic test_stall_release();
        do_reset();
        do_start(5'd0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            if (i > 0) begin
                n_checks++;
                if (got_rec !== mk_rec(((i-1)/4)%2, (i-1)%4, 0, i-1)) begin
                    n_fail++;
                    $display("FAIL stall_write word %0d: got %h want %h", i-1, got_rec, mk_rec(((i-1)/4)%2, (i-1)%4, 0, i-1));
                end
            end
            @(negedge clk_h);
        end
        s_data = 16'd8;
        n_checks++;
        if ({got_rec, s_ready, bank_valid, bank_rd_sel} !== {mk_rec(1, 3, 0, 7), 3'b010}) begin
            n_fail++;
            $display("FAIL stall_full: got %h want %h", {got_rec, s_ready, bank_valid, bank_rd_sel}, {mk_rec(1, 3, 0, 7), 3'b010});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_h);
            n_checks++;
            if ({act_wr_en, s_ready} !== 5'd0) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d: got %b want 0", k, {act_wr_en, s_ready});
            end
        end
        bank_release = 1'b1;
        @(negedge clk_h);
        bank_release = 1'b0;
        n_checks++;
        if ({bank_rd_sel, s_ready, bank_valid, act_wr_en} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL stall_after_release: got %b want 1110000", {bank_rd_sel, s_ready, bank_valid, act_wr_en});
        end
        for (int i = 8; i < 12; i++) begin
            s_data = 16'(i);
            if (i > 8) begin
                n_checks++;
                if (got_rec !== mk_rec(0, (i-1)%4, 0, i-1)) begin
                    n_fail++;
                    $display("FAIL stall_refill word %0d: got %h want %h", i-1, got_rec, mk_rec(0, (i-1)%4, 0, i-1));
                end
            end
            @(negedge clk_h);
        end
        s_valid = 1'b0;
        n_checks++;
        if ({got_rec, s_ready, bank_valid, bank_rd_sel} !== {mk_rec(0, 3, 0, 11), 3'b011}) begin
            n_fail++;
            $display("FAIL stall_refull: got %h want %h", {got_rec, s_ready, bank_valid, bank_rd_sel}, {mk_rec(0, 3, 0, 11), 3'b011});
        end
    endtask

    task automatic test_simul_release();
        do_reset();
        do_start(5'd0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            bank_release = (i == 7);
            @(negedge clk_h);
        end
        bank_release = 1'b0;
        n_checks++;
        if ({got_rec, bank_valid, bank_rd_sel, s_ready} !== {mk_rec(1, 3, 0, 7), 3'b111}) begin
            n_fail++;
            $display("FAIL simul_pointers: got %h want %h", {got_rec, bank_valid, bank_rd_sel, s_ready}, {mk_rec(1, 3, 0, 7), 3'b111});
        end
        s_data = 16'd8;
        @(negedge clk_h);
        s_valid = 1'b0;
        n_checks++;
        if (got_rec !== mk_rec(0, 0, 0, 8)) begin
            n_fail++;
            $display("FAIL simul_wr_bank: got %h want %h", got_rec, mk_rec(0, 0, 0, 8));
        end
        bank_release = 1'b1;
        @(negedge clk_h);
        bank_release = 1'b0;
        n_checks++;
        if ({bank_valid, bank_rd_sel, err_release} !== 3'b000) begin
            n_fail++;
            $display("FAIL simul_count_one: got %b want 000", {bank_valid, bank_rd_sel, err_release});
        end
    endtask

    task automatic test_err_release();
        do_reset();
        bank_release = 1'b1;
        @(negedge clk_h);
        bank_release = 1'b0;
        n_checks++;
        if ({err_release, bank_rd_sel, bank_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL err_set: got %b want 100", {err_release, bank_rd_sel, bank_valid});
        end
        @(negedge clk_h);
        n_checks++;
        if (err_release !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", err_release);
        end
        do_start(5'd0);
        n_checks++;
        if ({err_release, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL err_clear_by_start: got %b want 01", {err_release, busy});
        end
    endtask

    task automatic test_random_stream();
        int sent = 0;
        int tb_full = 0;
        logic tb_rd = 1'b0, tb_wb = 1'b0;
        logic [4:0] tb_w = '0;
        logic [1:0] tb_t = '0;
        logic [3:0] en;
        logic [25:0] exp_rec;
        int wrote = 0;
        do_reset();
        do_start(5'd31);
        exp_q.delete();
        for (int cyc = 0; cyc < 20000 && (sent < 1024 || exp_q.size() > 0); cyc++) begin
            if (exp_q.size() > 0) begin
                exp_rec = exp_q.pop_front();
                n_checks++;
                if (got_rec !== exp_rec) begin
                    n_fail++;
                    $display("FAIL rand_write cyc %0d: got %h want %h", cyc, got_rec, exp_rec);
                end
            end else if (act_wr_en !== 4'd0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_spurious cyc %0d: got en %b want 0000", cyc, act_wr_en);
            end
            n_checks++;
            if ({s_ready, bank_valid, bank_rd_sel} !== {tb_full < 2, tb_full != 0, tb_rd}) begin
                n_fail++;
                $display("FAIL rand_status cyc %0d: got %b want %b", cyc, {s_ready, bank_valid, bank_rd_sel}, {tb_full < 2, tb_full != 0, tb_rd});
            end
            s_valid = (sent < 1024) && ($urandom_range(0, 1) == 1);
            s_data = 16'(sent);
            bank_release = (tb_full != 0) && ($urandom_range(0, 299) == 0);
            if (s_valid && tb_full < 2) begin
                en = 4'b0001 << tb_t;
                exp_q.push_back({tb_wb, en, tb_w, s_data});
                sent++;
                if (tb_w == 5'd31) begin
                    tb_w = '0;
                    if (tb_t == 2'd3) begin
                        tb_t = '0; tb_wb = ~tb_wb; tb_full++;
                    end else begin
                        tb_t++;
                    end
                end else begin
                    tb_w++;
                end
            end
            if (bank_release) begin
                tb_rd = ~tb_rd; tb_full--;
            end
            @(negedge clk_h);
        end
        s_valid = 1'b0; bank_release = 1'b0;
        n_checks++;
        if (sent != 1024 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_timeout: sent %0d pending %0d want 1024 and 0", sent, exp_q.size());
        end
        // Mid-bank reset: wait for a live write, then hit rst between clock edges.
        for (int k = 0; k < 40 && wrote == 0; k++) begin
            if (act_wr_en != 4'd0) begin
                wrote = 1;
            end else begin
                s_valid = 1'b1;
                bank_release = bank_valid && !s_ready;
                @(negedge clk_h);
            end
        end
        n_checks++;
        if (wrote != 1) begin
            n_fail++;
            $display("FAIL midrst_write_seen: got %0d want 1", wrote);
        end
        bank_release = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({got_rec, bank_valid, bank_rd_sel, busy, err_release, s_ready} !== 31'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h want 0", {got_rec, bank_valid, bank_rd_sel, busy, err_release, s_ready});
        end
        s_valid = 1'b0;
        @(negedge clk_h);
        rst = 1'b0;
        do_start(5'd0);
        s_valid = 1'b1; s_data = 16'hbeef;
        @(negedge clk_h);
        s_valid = 1'b0;
        n_checks++;
        if (got_rec !== mk_rec(0, 0, 0, 16'hbeef)) begin
            n_fail++;
            $display("FAIL midrst_restart: got %h want %h", got_rec, mk_rec(0, 0, 0, 16'hbeef));
        end
    endtask

`ifdef ACT_LOADER_PERF_EN
    task automatic test_perf();
        do_reset();
        do_start(5'd0);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 16'(i);
            @(negedge clk_h);
        end
        repeat (10) @(negedge clk_h);
        s_valid = 1'b0;
        n_checks++;
        if ({perf_stall_cyc, perf_bank_cnt} !== {32'd10, 16'd2}) begin
            n_fail++;
            $display("FAIL perf_counts: got %0d/%0d want 10/2", perf_stall_cyc, perf_bank_cnt);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_fill_order();
        test_stall_release();
        test_simul_release();
        test_err_release();
        test_random_stream();
`ifdef ACT_LOADER_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
